// File: rtl/mmu_client_if.sv
// Signal bundle between mmu_client and its host, MMU request FIFOs and MMU response FIFOs.
// master = the client itself, slave = the surrounding host/MMU environment.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 4
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

interface mmu_client_if #(
  parameter int CNT_W = 5
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic                              cmd_is_free;
  logic [`REQ_SIZE_TYPE_WIDTH-1:0]   cmd_page_count;
  logic [`ALL_PAGE_IDX_WIDTH-1:0]    cmd_page_idx;

  logic                              alloc_req_write_en;
  logic [`REQ_ID_WIDTH-1:0]          alloc_req_id;
  logic [`REQ_SIZE_TYPE_WIDTH-1:0]   alloc_req_page_count;
  logic                              alloc_req_fifo_almost_full;

  logic                              free_req_write_en;
  logic [`REQ_ID_WIDTH-1:0]          free_req_id;
  logic [`ALL_PAGE_IDX_WIDTH-1:0]    free_req_page_idx;
  logic [`REQ_SIZE_TYPE_WIDTH-1:0]   free_req_page_count;
  logic                              free_req_fifo_almost_full;

  logic                              alloc_rsp_pop;
  logic [`REQ_ID_WIDTH-1:0]          alloc_rsp_id;
  logic [`ALL_PAGE_IDX_WIDTH-1:0]    alloc_rsp_page_idx;
  logic                              alloc_rsp_fail;
  logic [`FAIL_REASON_WIDTH-1:0]     alloc_rsp_fail_reason;
  logic                              alloc_rsp_fifo_empty;

  logic                              free_rsp_pop;
  logic [`REQ_ID_WIDTH-1:0]          free_rsp_id;
  logic                              free_rsp_fail;
  logic [`FAIL_REASON_WIDTH-1:0]     free_rsp_fail_reason;
  logic                              free_rsp_fifo_empty;

  logic                              res_valid;
  logic                              res_ready;
  logic                              res_is_free;
  logic [`REQ_ID_WIDTH-1:0]          res_id;
  logic [`ALL_PAGE_IDX_WIDTH-1:0]    res_page_idx;
  logic                              res_fail;
  logic [`FAIL_REASON_WIDTH-1:0]     res_fail_reason;

  logic [CNT_W-1:0]                  outstanding_count;
  logic                              id_error;

  modport master (
    input  cmd_valid, cmd_is_free, cmd_page_count, cmd_page_idx,
    output cmd_ready,
    output alloc_req_write_en, alloc_req_id, alloc_req_page_count,
    input  alloc_req_fifo_almost_full,
    output free_req_write_en, free_req_id, free_req_page_idx, free_req_page_count,
    input  free_req_fifo_almost_full,
    output alloc_rsp_pop,
    input  alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    input  alloc_rsp_fifo_empty,
    output free_rsp_pop,
    input  free_rsp_id, free_rsp_fail, free_rsp_fail_reason, free_rsp_fifo_empty,
    output res_valid, res_is_free, res_id, res_page_idx, res_fail, res_fail_reason,
    input  res_ready,
    output outstanding_count, id_error
  );

  modport slave (
    output cmd_valid, cmd_is_free, cmd_page_count, cmd_page_idx,
    input  cmd_ready,
    input  alloc_req_write_en, alloc_req_id, alloc_req_page_count,
    output alloc_req_fifo_almost_full,
    input  free_req_write_en, free_req_id, free_req_page_idx, free_req_page_count,
    output free_req_fifo_almost_full,
    input  alloc_rsp_pop,
    output alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    output alloc_rsp_fifo_empty,
    input  free_rsp_pop,
    output free_rsp_id, free_rsp_fail, free_rsp_fail_reason, free_rsp_fifo_empty,
    input  res_valid, res_is_free, res_id, res_page_idx, res_fail, res_fail_reason,
    output res_ready,
    input  outstanding_count, id_error
  );
endinterface

// File: rtl/mmu_client.sv
// MMU request initiator: hands out request IDs from a busy/type pool, pushes alloc/free requests,
// and merges both response FIFOs round-robin into one registered result stream that retires IDs.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 4
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module mmu_client #(
  parameter int ID_COUNT = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  mmu_client_if.master bus
);
  localparam int IDW = `REQ_ID_WIDTH;
  localparam int SZW = `REQ_SIZE_TYPE_WIDTH;
  localparam int PGW = `ALL_PAGE_IDX_WIDTH;
  localparam int FRW = `FAIL_REASON_WIDTH;

  logic [ID_COUNT-1:0] r_busy;
  logic [ID_COUNT-1:0] r_type;
  logic [CNT_W-1:0]    r_count;
  logic                r_id_error;
  logic                r_rr_free;

  logic                r_alloc_we;
  logic [IDW-1:0]      r_alloc_id;
  logic [SZW-1:0]      r_alloc_cnt;
  logic                r_free_we;
  logic [IDW-1:0]      r_free_id;
  logic [PGW-1:0]      r_free_idx;
  logic [SZW-1:0]      r_free_cnt;

  logic                r_res_valid;
  logic                r_res_is_free;
  logic [IDW-1:0]      r_res_id;
  logic [PGW-1:0]      r_res_page;
  logic                r_res_fail;
  logic [FRW-1:0]      r_res_reason;

  logic [IDW-1:0]      w_next_id;
  logic                w_pool_full;
  logic                w_target_af;
  logic                w_cmd_ready;
  logic                w_accept;
  logic                w_alloc_cand;
  logic                w_free_cand;
  logic                w_slot_free;
  logic                w_sel_free;
  logic                w_pop_alloc;
  logic                w_pop_free;
  logic                w_pop;
  logic [IDW-1:0]      w_rsp_id;
  logic                w_hit_busy;
  logic                w_hit_type;
  logic                w_retire;

  // Lowest-index free ID wins; scanning downward lets the smallest index overwrite.
  always_comb begin
    w_next_id = '0;
    for (int i = ID_COUNT - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_next_id = IDW'(i);
    end
  end

  assign w_pool_full = &r_busy;
  assign w_target_af = bus.cmd_is_free ? bus.free_req_fifo_almost_full
                                       : bus.alloc_req_fifo_almost_full;
  assign w_cmd_ready = rst_n & ~w_pool_full & ~w_target_af;
  assign w_accept    = bus.cmd_valid & w_cmd_ready;

  assign w_alloc_cand = ~bus.alloc_rsp_fifo_empty;
  assign w_free_cand  = ~bus.free_rsp_fifo_empty;
  assign w_slot_free  = ~r_res_valid | bus.res_ready;
  assign w_sel_free   = w_free_cand & (~w_alloc_cand | r_rr_free);
  assign w_pop_alloc  = rst_n & w_slot_free & w_alloc_cand & ~w_sel_free;
  assign w_pop_free   = rst_n & w_slot_free & w_free_cand & w_sel_free;
  assign w_pop        = w_pop_alloc | w_pop_free;
  assign w_rsp_id     = w_sel_free ? bus.free_rsp_id : bus.alloc_rsp_id;

  // IDs outside 0..ID_COUNT-1 never match, so they fall through as unknown responses.
  always_comb begin
    w_hit_busy = 1'b0;
    w_hit_type = 1'b0;
    for (int i = 0; i < ID_COUNT; i++) begin
      if (w_rsp_id == IDW'(i)) begin
        w_hit_busy = r_busy[i];
        w_hit_type = r_type[i];
      end
    end
  end

  assign w_retire = w_pop & w_hit_busy & (w_hit_type == w_sel_free);

  // Accept and retire can never target the same ID: one is free, the other busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_type <= '0;
    end else begin
      for (int i = 0; i < ID_COUNT; i++) begin
        if (w_retire && (w_rsp_id == IDW'(i))) r_busy[i] <= 1'b0;
        if (w_accept && (w_next_id == IDW'(i))) begin
          r_busy[i] <= 1'b1;
          r_type[i] <= bus.cmd_is_free;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_id_error <= 1'b0;
      r_rr_free  <= 1'b0;
    end else begin
      if (w_accept && !w_retire) r_count <= r_count + CNT_W'(1);
      else if (!w_accept && w_retire) r_count <= r_count - CNT_W'(1);
      if (w_pop && !w_retire) r_id_error <= 1'b1;
      if (w_pop) r_rr_free <= ~w_sel_free;
    end
  end

  // Request fields only move on an accept of their own type, otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_we  <= 1'b0;
      r_alloc_id  <= '0;
      r_alloc_cnt <= '0;
      r_free_we   <= 1'b0;
      r_free_id   <= '0;
      r_free_idx  <= '0;
      r_free_cnt  <= '0;
    end else begin
      r_alloc_we <= w_accept & ~bus.cmd_is_free;
      r_free_we  <= w_accept & bus.cmd_is_free;
      if (w_accept && !bus.cmd_is_free) begin
        r_alloc_id  <= w_next_id;
        r_alloc_cnt <= bus.cmd_page_count;
      end
      if (w_accept && bus.cmd_is_free) begin
        r_free_id  <= w_next_id;
        r_free_idx <= bus.cmd_page_idx;
        r_free_cnt <= bus.cmd_page_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid   <= 1'b0;
      r_res_is_free <= 1'b0;
      r_res_id      <= '0;
      r_res_page    <= '0;
      r_res_fail    <= 1'b0;
      r_res_reason  <= '0;
    end else if (w_pop) begin
      r_res_valid   <= 1'b1;
      r_res_is_free <= w_sel_free;
      r_res_id      <= w_rsp_id;
      r_res_page    <= w_sel_free ? '0 : bus.alloc_rsp_page_idx;
      r_res_fail    <= w_sel_free ? bus.free_rsp_fail : bus.alloc_rsp_fail;
      r_res_reason  <= w_sel_free ? bus.free_rsp_fail_reason : bus.alloc_rsp_fail_reason;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready            = w_cmd_ready;
  assign bus.alloc_req_write_en   = r_alloc_we;
  assign bus.alloc_req_id         = r_alloc_id;
  assign bus.alloc_req_page_count = r_alloc_cnt;
  assign bus.free_req_write_en    = r_free_we;
  assign bus.free_req_id          = r_free_id;
  assign bus.free_req_page_idx    = r_free_idx;
  assign bus.free_req_page_count  = r_free_cnt;
  assign bus.alloc_rsp_pop        = w_pop_alloc;
  assign bus.free_rsp_pop         = w_pop_free;
  assign bus.res_valid            = r_res_valid;
  assign bus.res_is_free          = r_res_is_free;
  assign bus.res_id               = r_res_id;
  assign bus.res_page_idx         = r_res_page;
  assign bus.res_fail             = r_res_fail;
  assign bus.res_fail_reason      = r_res_reason;
  assign bus.outstanding_count    = r_count;
  assign bus.id_error             = r_id_error;
endmodule

// File: tb/tb_mmu_client.sv
// Scoreboard bench for mmu_client: a behavioural pool/arbiter model predicts handshakes each
// cycle and queues expected requests/results; a separate monitor compares what the DUT emits.
`timescale 1ns/1ps
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 4
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module tb_mmu_client;
  localparam int ID_COUNT = 4;
  localparam int CNT_W    = 3;
  localparam int IDW      = `REQ_ID_WIDTH;
  localparam int SZW      = `REQ_SIZE_TYPE_WIDTH;
  localparam int PGW      = `ALL_PAGE_IDX_WIDTH;
  localparam int FRW      = `FAIL_REASON_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mmu_client_if #(.CNT_W(CNT_W)) bus();

  mmu_client #(.ID_COUNT(ID_COUNT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { bit isFree; int id; int cnt; int idx; } req_t;
  typedef struct { bit isFree; int id; int page; bit fail; int reason; } rsp_t;

  req_t reqQ[$];
  rsp_t resQ[$];
  rsp_t allocFifo[$];
  rsp_t freeFifo[$];
  req_t pending[$];

  bit mBusy[ID_COUNT];
  bit mTypeFree[ID_COUNT];
  bit mErr;
  bit mResValid;
  bit mLastFree;

  int tests = 0;
  int fails = 0;

  function automatic void checkOutput(string name, int actual, int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endfunction

  function automatic int busyCount();
    int n = 0;
    foreach (mBusy[i]) n += int'(mBusy[i]);
    return n;
  endfunction

  function automatic int lowestFree();
    for (int i = 0; i < ID_COUNT; i++) if (!mBusy[i]) return i;
    return -1;
  endfunction

  function automatic void modelReset();
    foreach (mBusy[i]) begin
      mBusy[i]     = 1'b0;
      mTypeFree[i] = 1'b0;
    end
    mErr      = 1'b0;
    mResValid = 1'b0;
    mLastFree = 1'b1;
    reqQ.delete();
    resQ.delete();
    allocFifo.delete();
    freeFifo.delete();
    pending.delete();
  endfunction

  function automatic void pushRsp(bit isFree, int id, int page, bit fail, int reason);
    rsp_t r;
    r.isFree = isFree;
    r.id     = id;
    r.page   = isFree ? 0 : page;
    r.fail   = fail;
    r.reason = reason;
    if (isFree) freeFifo.push_back(r);
    else allocFifo.push_back(r);
  endfunction

  function automatic void respondId(bit isFree, int id, int page, bit fail, int reason);
    for (int i = 0; i < pending.size(); i++) begin
      if (pending[i].id == id && pending[i].isFree == isFree) begin
        pending.delete(i);
        break;
      end
    end
    pushRsp(isFree, id, page, fail, reason);
  endfunction

  function automatic void respondRandom();
    int k;
    req_t p;
    k = $urandom_range(pending.size() - 1);
    p = pending[k];
    pending.delete(k);
    pushRsp(p.isFree, p.id, $urandom_range(255), $urandom_range(7) == 0, $urandom_range(3));
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_is_free = 1'b0;
    bus.cmd_page_count = '0;
    bus.cmd_page_idx = '0;
    bus.alloc_req_fifo_almost_full = 1'b0;
    bus.free_req_fifo_almost_full = 1'b0;
    bus.alloc_rsp_fifo_empty = 1'b1;
    bus.free_rsp_fifo_empty = 1'b1;
    bus.alloc_rsp_id = '0;
    bus.alloc_rsp_page_idx = '0;
    bus.alloc_rsp_fail = 1'b0;
    bus.alloc_rsp_fail_reason = '0;
    bus.free_rsp_id = '0;
    bus.free_rsp_fail = 1'b0;
    bus.free_rsp_fail_reason = '0;
    bus.res_ready = 1'b0;
    #1;
    checkOutput("resetOutputsZero", int'(|{bus.cmd_ready, bus.alloc_req_write_en, bus.alloc_req_id,
      bus.alloc_req_page_count, bus.free_req_write_en, bus.free_req_id, bus.free_req_page_idx,
      bus.free_req_page_count, bus.alloc_rsp_pop, bus.free_rsp_pop, bus.res_valid, bus.res_is_free,
      bus.res_id, bus.res_page_idx, bus.res_fail, bus.res_fail_reason, bus.outstanding_count}), 0);
    checkOutput("resetIdError", int'(bus.id_error), 0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic applyStimulus(input bit valid, input bit isFree, input int cnt, input int idx,
                               input bit resReady, input bit allocAf, input bit freeAf);
    bit expReady, aC, fC, slot, selFree, popA, popF;
    int newId;
    rsp_t r;
    bus.cmd_valid = valid;
    bus.cmd_is_free = isFree;
    bus.cmd_page_count = SZW'(cnt);
    bus.cmd_page_idx = PGW'(idx);
    bus.res_ready = resReady;
    bus.alloc_req_fifo_almost_full = allocAf;
    bus.free_req_fifo_almost_full = freeAf;
    aC = allocFifo.size() > 0;
    fC = freeFifo.size() > 0;
    bus.alloc_rsp_fifo_empty = !aC;
    bus.free_rsp_fifo_empty = !fC;
    if (aC) begin
      bus.alloc_rsp_id = IDW'(allocFifo[0].id);
      bus.alloc_rsp_page_idx = PGW'(allocFifo[0].page);
      bus.alloc_rsp_fail = allocFifo[0].fail;
      bus.alloc_rsp_fail_reason = FRW'(allocFifo[0].reason);
    end
    if (fC) begin
      bus.free_rsp_id = IDW'(freeFifo[0].id);
      bus.free_rsp_fail = freeFifo[0].fail;
      bus.free_rsp_fail_reason = FRW'(freeFifo[0].reason);
    end
    #1;
    checkOutput("outstandingCount", int'(bus.outstanding_count), busyCount());
    checkOutput("idError", int'(bus.id_error), int'(mErr));
    expReady = (busyCount() < ID_COUNT) && !(isFree ? freeAf : allocAf);
    slot     = !mResValid || resReady;
    selFree  = fC && (!aC || !mLastFree);
    popA     = slot && aC && !selFree;
    popF     = slot && fC && selFree;
    checkOutput("cmdReady", int'(bus.cmd_ready), int'(expReady));
    checkOutput("allocRspPop", int'(bus.alloc_rsp_pop), int'(popA));
    checkOutput("freeRspPop", int'(bus.free_rsp_pop), int'(popF));
    if (mResValid && resReady) mResValid = 1'b0;
    newId = -1;
    if (valid && expReady) begin
      newId = lowestFree();
      reqQ.push_back('{isFree: isFree, id: newId, cnt: cnt % 4, idx: idx % 256});
    end
    if (popA || popF) begin
      r = popF ? freeFifo.pop_front() : allocFifo.pop_front();
      if (r.id < ID_COUNT && mBusy[r.id] && mTypeFree[r.id] == r.isFree) mBusy[r.id] = 1'b0;
      else mErr = 1'b1;
      resQ.push_back(r);
      mResValid = 1'b1;
      mLastFree = popF;
    end
    if (newId >= 0) begin
      mBusy[newId]     = 1'b1;
      mTypeFree[newId] = isFree;
      pending.push_back('{isFree: isFree, id: newId, cnt: 0, idx: 0});
    end
    @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("reqQueueDrained", reqQ.size(), 0);
    checkOutput("resQueueDrained", resQ.size(), 0);
    checkOutput("rspFifosDrained", allocFifo.size() + freeFifo.size(), 0);
  endtask

  // Monitor: compares every request write and every presented result against the scoreboard.
  initial begin
    req_t e;
    rsp_t x;
    forever begin
      @(negedge clk);
      #2;
      checkOutput("singleReqWrite", int'(bus.alloc_req_write_en & bus.free_req_write_en), 0);
      if (bus.alloc_req_write_en || bus.free_req_write_en) begin
        checkOutput("reqExpected", int'(reqQ.size() > 0), 1);
        if (reqQ.size() > 0) begin
          e = reqQ.pop_front();
          checkOutput("reqIsFree", int'(bus.free_req_write_en), int'(e.isFree));
          if (e.isFree) begin
            checkOutput("freeReqId", int'(bus.free_req_id), e.id);
            checkOutput("freeReqIdx", int'(bus.free_req_page_idx), e.idx);
            checkOutput("freeReqCount", int'(bus.free_req_page_count), e.cnt);
          end else begin
            checkOutput("allocReqId", int'(bus.alloc_req_id), e.id);
            checkOutput("allocReqCount", int'(bus.alloc_req_page_count), e.cnt);
          end
        end
      end
      if (bus.res_valid) begin
        checkOutput("resExpected", int'(resQ.size() > 0), 1);
        if (resQ.size() > 0) begin
          x = resQ[0];
          checkOutput("resIsFree", int'(bus.res_is_free), int'(x.isFree));
          checkOutput("resId", int'(bus.res_id), x.id);
          checkOutput("resPageIdx", int'(bus.res_page_idx), x.page);
          checkOutput("resFail", int'(bus.res_fail), int'(x.fail));
          checkOutput("resFailReason", int'(bus.res_fail_reason), x.reason);
          if (bus.res_ready) void'(resQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    doReset();

    repeat (3) applyStimulus(1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1, 'h11, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0);

    respondId(1'b0, 2, 'h40, 1'b0, 0);
    repeat (2) applyStimulus(1'b1, 1'b1, 2, 'h40, 1'b1, 1'b0, 1'b0);
    respondId(1'b0, 0, 'h13, 1'b0, 0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1, 'h22, 1'b1, 1'b0, 1'b0);

    respondId(1'b0, 1, 'h51, 1'b0, 0);
    respondId(1'b0, 3, 'h53, 1'b1, 2);
    respondId(1'b1, 0, 0, 1'b0, 0);
    respondId(1'b1, 2, 0, 1'b1, 1);
    repeat (6) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

    repeat (2) applyStimulus(1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0);
    respondId(1'b0, 0, 'h61, 1'b0, 0);
    respondId(1'b0, 1, 'h62, 1'b0, 0);
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      if (pending.size() > 0 && $urandom_range(2) == 0) respondRandom();
      applyStimulus($urandom_range(2) != 0, 1'($urandom_range(1)), $urandom_range(3),
                    $urandom_range(255), $urandom_range(3) != 0,
                    $urandom_range(4) == 0, $urandom_range(4) == 0);
    end
    drain(12);

    pushRsp(1'b0, 5, 'h07, 1'b1, 3);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    if (pending.size() > 0) pushRsp(!pending[0].isFree, pending[0].id, 'h33, 1'b0, 1);
    drain(6);

    doReset();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmu_client.md
Name: mmu_client

Overview:
- Request-initiator counterpart of the MMU tree.
- Accepts host alloc/free commands, assigns request IDs from a tracked pool, and pushes requests into the alloc/free request FIFOs.
- Drains the alloc/free response FIFOs, retires the matching IDs, and presents one merged result stream to the host.
- Sits between a host/traffic source and the MMU's request and response FIFOs.

Parameters:
- ID_COUNT, 16: number of usable request IDs, 1..2^`REQ_ID_WIDTH; IDs are 0..ID_COUNT-1.
- CNT_W, 5: width of outstanding_count; must satisfy 2^CNT_W > ID_COUNT.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_is_free  in  1  1=free, 0=alloc
- cmd_page_count  in  `REQ_SIZE_TYPE_WIDTH  size type
- cmd_page_idx  in  `ALL_PAGE_IDX_WIDTH  page index (free only)
- alloc_req_write_en  out  1  push to alloc req FIFO
- alloc_req_id  out  `REQ_ID_WIDTH  request ID
- alloc_req_page_count  out  `REQ_SIZE_TYPE_WIDTH  size type
- alloc_req_fifo_almost_full  in  1  alloc req FIFO backpressure
- free_req_write_en  out  1  push to free req FIFO
- free_req_id  out  `REQ_ID_WIDTH  request ID
- free_req_page_idx  out  `ALL_PAGE_IDX_WIDTH  page index
- free_req_page_count  out  `REQ_SIZE_TYPE_WIDTH  size type
- free_req_fifo_almost_full  in  1  free req FIFO backpressure
- alloc_rsp_pop  out  1  pop alloc rsp FIFO
- alloc_rsp_id  in  `REQ_ID_WIDTH  head ID
- alloc_rsp_page_idx  in  `ALL_PAGE_IDX_WIDTH  head page index
- alloc_rsp_fail  in  1  head fail flag
- alloc_rsp_fail_reason  in  `FAIL_REASON_WIDTH  head fail reason
- alloc_rsp_fifo_empty  in  1  alloc rsp FIFO empty
- free_rsp_pop  out  1  pop free rsp FIFO
- free_rsp_id  in  `REQ_ID_WIDTH  head ID
- free_rsp_fail  in  1  head fail flag
- free_rsp_fail_reason  in  `FAIL_REASON_WIDTH  head fail reason
- free_rsp_fifo_empty  in  1  free rsp FIFO empty
- res_valid  out  1  result valid
- res_ready  in  1  host accepts result
- res_is_free  out  1  result type
- res_id  out  `REQ_ID_WIDTH  result ID
- res_page_idx  out  `ALL_PAGE_IDX_WIDTH  page index (0 for free results)
- res_fail  out  1  fail flag
- res_fail_reason  out  `FAIL_REASON_WIDTH  fail reason
- outstanding_count  out  CNT_W  number of busy IDs
- id_error  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0; ID pool all free; type bits 0; result register empty; round-robin pointer = alloc. Reset mid-operation discards in-flight state; no retire is generated.
- Response FIFOs are first-word-fall-through: head data is valid while empty=0; pop consumes it at the clock edge.

Command path:
- Pool: busy bit and type bit per ID. next_id = lowest-index free ID.
- cmd_ready = pool not exhausted & !(target FIFO almost_full), where target = cmd_is_free ? free : alloc. Combinational in cmd_is_free.
- On accept at edge N:
  - next_id is marked busy; type bit = cmd_is_free.
  - The matching *_req_write_en is high for exactly the cycle after edge N, with id/count/idx registered.
  - Request fields hold their last values when write_en=0.
- At most one request per cycle. Back-to-back accepts give write_en high on consecutive cycles.

Response path:
- One-entry result register. slot_free = !res_valid | res_ready.
- Candidates: alloc (!alloc_rsp_fifo_empty), free (!free_rsp_fifo_empty).
  - If both: serve the one not served last (round-robin).
  - If one: serve it.
- Pop is combinational: exactly one of alloc_rsp_pop/free_rsp_pop = candidate & selected & slot_free; never both.
- At the pop edge:
  - Head data is captured into the result register; res_valid=1 next cycle.
  - If the ID is busy with a matching type bit, it is cleared (retired).
- Host consumes with res_valid&res_ready. A full throughput of one result per cycle is sustained.
- Unknown/mismatched response (ID not busy, ID ≥ ID_COUNT, or type mismatch): result still forwarded; pool unchanged; id_error set to 1, sticky until reset.

Counting and simultaneous events:
- outstanding_count = +1 on accept, −1 on valid retire; net 0 when both occur in the same cycle.
- Retire and accept in the same cycle: next_id is computed from the pre-edge pool, so the retiring ID is not reused that cycle. It becomes available the following cycle.
- Pool exhausted: cmd_ready=0 until a retire. outstanding_count never exceeds ID_COUNT.

Test Plan:
- Reset, then 3 alloc cmds (count=2) back-to-back, FIFOs not full -> alloc_req_write_en high 3 consecutive cycles, IDs 0,1,2, first one cycle after first accept; outstanding_count=3.
- ID_COUNT=4, 4 allocs accepted, then cmd_valid held -> cmd_ready=0. Push alloc rsp id=2 (page_idx=0x40) -> result id=2, page_idx=0x40, res_is_free=0. Next accepted cmd gets ID 2.
- Free cmd while free_req_fifo_almost_full=1 -> cmd_ready=0, no write. Alloc cmd in same state with alloc FIFO not full -> accepted.
- Both rsp FIFOs hold 2 entries, res_ready=1 -> pops alternate alloc, free, alloc, free. No cycle has both pops. Four results on 4 consecutive cycles.
- res_ready=0 with a pending result and rsp FIFOs non-empty -> no pops, result held stable. res_ready=1 -> drains one per cycle.
- Rsp with id=5 never issued (fail=1, reason=3) -> result forwarded with fail=1, reason=3; id_error=1 and stays 1; outstanding_count unchanged. Assert rst_n=0 -> id_error=0 and all outputs 0.
